// File: rtl/mult32x32_sched.sv
// rtl/mult32x32_sched.sv - two-port arbiter and partial-product sequencer for a shared 32x32 multiplier
module mult32x32_sched #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic [31:0] i_a0,
    input  logic [31:0] i_a1,
    input  logic [31:0] i_b0,
    input  logic [31:0] i_b1,
    output logic        o_ack0,
    output logic        o_ack1,
    output logic        o_busy,
    output logic        o_res_valid,
    input  logic        i_res_ready,
    output logic        o_res_id,
    output logic [63:0] o_res_data,
    output logic [31:0] o_mul_a,
    output logic [31:0] o_mul_b,
    output logic        o_mul_a_sel,
    output logic        o_mul_b_sel,
    output logic [1:0]  o_mul_shift,
    output logic        o_mul_upd,
    output logic        o_mul_clr,
    input  logic [63:0] i_mul_product
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P00  = 3'd1,
        S_P01  = 3'd2,
        S_P10  = 3'd3,
        S_P11  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last_grant;
    logic        r_res_id;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;

    logic        w_grant;
    logic        w_grant_id;
    logic        w_a_sel;
    logic        w_b_sel;
    logic [1:0]  w_shift;
    logic        w_upd;

    // Arbiter: pick the winner among pending requests; a tie alternates in round-robin mode
    always_comb begin
        w_grant_id = 1'b0;
        if (i_req0 && i_req1) begin
            w_grant_id = RR_EN ? ~r_last_grant : 1'b0;
        end else if (i_req1) begin
            w_grant_id = 1'b1;
        end
    end

    // Grants only happen from IDLE; held off while reset is asserted so all outputs read 0
    assign w_grant = (r_state == S_IDLE) && (i_req0 || i_req1) && !i_reset;

    // Next-state and multiplier controls: one partial product per Px state, lo*lo first
    always_comb begin
        w_next  = r_state;
        w_a_sel = 1'b0;
        w_b_sel = 1'b0;
        w_shift = 2'b00;
        w_upd   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) w_next = S_P00;
            end
            S_P00: begin
                w_upd  = 1'b1;
                w_next = S_P01;
            end
            S_P01: begin
                w_b_sel = 1'b1;
                w_shift = 2'b01;
                w_upd   = 1'b1;
                w_next  = S_P10;
            end
            S_P10: begin
                w_a_sel = 1'b1;
                w_shift = 2'b01;
                w_upd   = 1'b1;
                w_next  = S_P11;
            end
            S_P11: begin
                w_a_sel = 1'b1;
                w_b_sel = 1'b1;
                w_shift = 2'b10;
                w_upd   = 1'b1;
                w_next  = S_DONE;
            end
            S_DONE: begin
                if (i_res_ready) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand and owner latches, captured only on the grant edge
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_res_id     <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_grant) begin
            r_mul_a      <= w_grant_id ? i_a1 : i_a0;
            r_mul_b      <= w_grant_id ? i_b1 : i_b0;
            r_res_id     <= w_grant_id;
            r_last_grant <= w_grant_id;
        end
    end

    assign o_ack0      = w_grant && !w_grant_id;
    assign o_ack1      = w_grant && w_grant_id;
    assign o_mul_clr   = w_grant;
    assign o_busy      = (r_state != S_IDLE);
    assign o_res_valid = (r_state == S_DONE);
    assign o_res_id    = r_res_id;
    assign o_res_data  = i_mul_product;
    assign o_mul_a     = r_mul_a;
    assign o_mul_b     = r_mul_b;
    assign o_mul_a_sel = w_a_sel;
    assign o_mul_b_sel = w_b_sel;
    assign o_mul_shift = w_shift;
    assign o_mul_upd   = w_upd;

endmodule

// File: tb/tb_mult32x32_sched.sv
// tb/tb_mult32x32_sched.sv - self-checking bench for mult32x32_sched
module tb_mult32x32_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, res_ready = 1'b1;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

    logic        ack0, ack1, busy, res_valid, res_id, a_sel, b_sel, upd, clr;
    logic [1:0]  shift;
    logic [31:0] mul_a, mul_b;
    logic [63:0] res_data;
    logic [63:0] prod;

    logic        f_ack0, f_ack1, f_busy, f_res_valid, f_res_id, f_a_sel, f_b_sel, f_upd, f_clr;
    logic [1:0]  f_shift;
    logic [31:0] f_mul_a, f_mul_b;
    logic [63:0] f_res_data;
    logic [63:0] f_prod;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult32x32_sched #(.RR_EN(1'b1)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_req0(req0), .i_req1(req1),
        .i_a0(a0), .i_a1(a1), .i_b0(b0), .i_b1(b1),
        .o_ack0(ack0), .o_ack1(ack1), .o_busy(busy), .o_res_valid(res_valid),
        .i_res_ready(res_ready), .o_res_id(res_id), .o_res_data(res_data),
        .o_mul_a(mul_a), .o_mul_b(mul_b), .o_mul_a_sel(a_sel), .o_mul_b_sel(b_sel),
        .o_mul_shift(shift), .o_mul_upd(upd), .o_mul_clr(clr), .i_mul_product(prod)
    );

    mult32x32_sched #(.RR_EN(1'b0)) u_fp (
        .i_clk(clk), .i_reset(rst), .i_req0(req0), .i_req1(req1),
        .i_a0(a0), .i_a1(a1), .i_b0(b0), .i_b1(b1),
        .o_ack0(f_ack0), .o_ack1(f_ack1), .o_busy(f_busy), .o_res_valid(f_res_valid),
        .i_res_ready(res_ready), .o_res_id(f_res_id), .o_res_data(f_res_data),
        .o_mul_a(f_mul_a), .o_mul_b(f_mul_b), .o_mul_a_sel(f_a_sel), .o_mul_b_sel(f_b_sel),
        .o_mul_shift(f_shift), .o_mul_upd(f_upd), .o_mul_clr(f_clr), .i_mul_product(f_prod)
    );

    function automatic logic [63:0] partial(input logic [31:0] a, input logic [31:0] b,
                                            input logic asel, input logic bsel, input logic [1:0] sh);
        logic [63:0] x, y;
        x = asel ? {48'd0, a[31:16]} : {48'd0, a[15:0]};
        y = bsel ? {48'd0, b[31:16]} : {48'd0, b[15:0]};
        return (x * y) << (16 * sh);
    endfunction

    // Arithmetic unit behaviour for each scheduler instance
    always @(posedge clk or posedge rst) begin
        if (rst)      prod <= '0;
        else if (clr) prod <= '0;
        else if (upd) prod <= prod + partial(mul_a, mul_b, a_sel, b_sel, shift);
    end

    always @(posedge clk or posedge rst) begin
        if (rst)        f_prod <= '0;
        else if (f_clr) f_prod <= '0;
        else if (f_upd) f_prod <= f_prod + partial(f_mul_a, f_mul_b, f_a_sel, f_b_sel, f_shift);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected {a_sel,b_sel,shift,upd} for each phase of an operation (0 = idle, 5 = done)
    function automatic logic [4:0] ctl_of(input int ph);
        case (ph)
            1:       return 5'b00001;
            2:       return 5'b01011;
            3:       return 5'b10011;
            4:       return 5'b11101;
            default: return 5'b00000;
        endcase
    endfunction

    // Reference model: phase counter since grant, operands of the owner, arbitration history
    int          m_phase = 0;
    bit          m_last  = 1'b1;
    bit          m_id    = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;
    bit          m_any, m_g;
    int          w_cnt0 = 0, w_cnt1 = 0;
    int          n_done = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ctrl", 64'({ack0, ack1, busy, res_valid, res_id, a_sel, b_sel, shift, upd, clr}), 64'(0));
            chk("rst_mul_ab", {mul_a, mul_b}, 64'(0));
            chk("rst_res_data", res_data, 64'(0));
            m_phase = 0; m_last = 1'b1; m_id = 1'b0; m_a = '0; m_b = '0;
            w_cnt0 = 0; w_cnt1 = 0;
        end else begin
            m_any = (m_phase == 0) && (req0 || req1);
            if (req0 && req1) m_g = m_last ? 1'b0 : 1'b1;
            else              m_g = req1;
            chk("ack0", 64'(ack0), 64'(m_any && !m_g));
            chk("ack1", 64'(ack1), 64'(m_any && m_g));
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("res_valid", 64'(res_valid), 64'(m_phase == 5));
            chk("res_id", 64'(res_id), 64'(m_id));
            chk("mul_ab", {mul_a, mul_b}, {m_a, m_b});
            chk("ctrl", 64'({clr, a_sel, b_sel, shift, upd}), 64'({m_any, ctl_of(m_phase)}));
            if (m_phase == 5) chk("res_data", res_data, {32'd0, m_a} * {32'd0, m_b});
            if (!req0) w_cnt0 = 0;
            if (!req1) w_cnt1 = 0;
            if (m_any) begin
                if (m_g) begin
                    w_cnt1 = 0;
                    if (req0) begin w_cnt0++; chk("wait_bound0", 64'(w_cnt0 <= 1), 64'(1)); end
                end else begin
                    w_cnt0 = 0;
                    if (req1) begin w_cnt1++; chk("wait_bound1", 64'(w_cnt1 <= 1), 64'(1)); end
                end
                m_a = m_g ? a1 : a0;
                m_b = m_g ? b1 : b0;
                m_id = m_g; m_last = m_g; m_phase = 1;
            end else if (m_phase >= 1 && m_phase <= 4) begin
                m_phase++;
            end else if (m_phase == 5 && res_ready) begin
                m_phase = 0; n_done++;
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic wait_ack(input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin ok = 1'b1; break; end
            tick();
        end
        chk("ack_seen", 64'(ok), 64'(1));
    endtask

    task automatic wait_valid(input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1'b1; break; end
            tick();
        end
        chk("valid_seen", 64'(ok), 64'(1));
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_op;
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_FFFF;
            3:       return 32'hFFFF_0000;
            default: return $urandom;
        endcase
    endfunction

    logic [4:0] ctl_lit [4] = '{5'b00001, 5'b01011, 5'b10011, 5'b11101};

    initial begin
        #900000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int start_done;
        int cyc;
        bit seen0, seen1;

        // Reset state
        @(negedge clk);
        chk("lit_reset_busy", 64'(busy), 64'(0));
        chk("lit_reset_valid", 64'(res_valid), 64'(0));
        tick(); tick();
        rst = 1'b0;

        // Single op with all-ones operands and control trace
        res_ready = 1'b1;
        req0 = 1'b1; a0 = 32'hFFFF_FFFF; b0 = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("lit_t1_ack0", 64'(ack0), 64'(1));
        chk("lit_t1_clr", 64'(clr), 64'(1));
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) req0 = 1'b0;
            @(negedge clk);
            chk("lit_t3_ctrl", 64'({a_sel, b_sel, shift, upd}), 64'(ctl_lit[k-1]));
            chk("lit_t3_noclr", 64'(clr), 64'(0));
        end
        tick();
        @(negedge clk);
        chk("lit_t1_valid_c5", 64'(res_valid), 64'(1));
        chk("lit_t1_data", res_data, 64'hFFFF_FFFE_0000_0001);
        chk("lit_t1_id", 64'(res_id), 64'(0));
        tick();

        // Arbitration: tie after reset, then round-robin vs fixed priority
        do_reset();
        req0 = 1'b1; a0 = 32'd3; b0 = 32'd5;
        req1 = 1'b1; a1 = 32'h0001_0000; b1 = 32'h0001_0000;
        wait_ack(4);
        chk("lit_t2_ack0", 64'({ack0, ack1}), 64'(2'b10));
        chk("lit_t2_fp_ack0", 64'({f_ack0, f_ack1}), 64'(2'b10));
        tick(); req0 = 1'b0;
        wait_valid(10);
        chk("lit_t2_data0", res_data, 64'd15);
        chk("lit_t2_id0", 64'(res_id), 64'(0));
        chk("lit_t2_fp_data0", f_res_data, 64'd15);
        chk("lit_t2_fp_state", 64'({f_busy, f_res_valid, f_res_id}), 64'(3'b110));
        tick();
        wait_ack(4);
        chk("lit_t2_ack1", 64'({ack0, ack1}), 64'(2'b01));
        tick(); req1 = 1'b0;
        wait_valid(10);
        chk("lit_t2_data1", res_data, 64'h0000_0001_0000_0000);
        chk("lit_t2_id1", 64'(res_id), 64'(1));
        tick();
        req0 = 1'b1; req1 = 1'b1;
        wait_ack(4);
        chk("lit_t2_rr_tie", 64'({ack0, ack1}), 64'(2'b10));
        chk("lit_t2_fp_tie", 64'({f_ack0, f_ack1}), 64'(2'b10));
        tick();
        wait_ack(10);
        chk("lit_t2_rr_alt", 64'({ack0, ack1}), 64'(2'b01));
        chk("lit_t2_fp_again", 64'({f_ack0, f_ack1}), 64'(2'b10));
        tick(); req0 = 1'b0; req1 = 1'b0;
        for (int k = 0; k < 8; k++) tick();

        // Backpressure holds the result and blocks the pending requester
        res_ready = 1'b0;
        req0 = 1'b1; a0 = 32'h0001_0002; b0 = 32'h0003_0004;
        wait_ack(4);
        tick(); req0 = 1'b0; req1 = 1'b1; a1 = 32'd7; b1 = 32'd9;
        wait_valid(10);
        for (int k = 0; k < 10; k++) begin
            chk("lit_t4_hold_valid", 64'(res_valid), 64'(1));
            chk("lit_t4_hold_data", res_data, 64'h0000_0003_000A_0008);
            chk("lit_t4_hold_id", 64'(res_id), 64'(0));
            chk("lit_t4_no_ack1", 64'(ack1), 64'(0));
            tick();
            @(negedge clk);
        end
        tick(); res_ready = 1'b1;
        @(negedge clk);
        chk("lit_t4_still_done", 64'({res_valid, ack1}), 64'(2'b10));
        tick();
        @(negedge clk);
        chk("lit_t4_ack1", 64'(ack1), 64'(1));
        tick(); req1 = 1'b0;
        wait_valid(10);
        chk("lit_t4_data1", res_data, 64'd63);
        chk("lit_t4_id1", 64'(res_id), 64'(1));
        tick();

        // Reset during P01 aborts asynchronously; request is re-granted afterwards
        req0 = 1'b1; a0 = 32'h8000_0001; b0 = 32'h0000_FFFF;
        wait_ack(4);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("lit_t5_async_ctrl", 64'({ack0, ack1, busy, res_valid, res_id, a_sel, b_sel, shift, upd, clr}), 64'(0));
        chk("lit_t5_async_ab", {mul_a, mul_b}, 64'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("lit_t5_reack", 64'(ack0), 64'(1));
        tick(); req0 = 1'b0;
        wait_valid(10);
        chk("lit_t5_data", res_data, 64'h0000_7FFF_8000_FFFF);
        tick();

        // Random traffic on both ports with random backpressure
        start_done = n_done;
        seen0 = 1'b0; seen1 = 1'b0;
        cyc = 0;
        while ((n_done - start_done) < 1000 && cyc < 60000) begin
            if (req0 && seen0)                        req0 = 1'b0;
            else if (req0 && $urandom_range(0, 19) == 0) req0 = 1'b0;
            else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; a0 = rand_op(); b0 = rand_op();
            end
            if (req1 && seen1)                        req1 = 1'b0;
            else if (req1 && $urandom_range(0, 19) == 0) req1 = 1'b0;
            else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; a1 = rand_op(); b1 = rand_op();
            end
            res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            seen0 = ack0; seen1 = ack1;
            tick();
            cyc++;
        end
        chk("random_ops_done", 64'((n_done - start_done) >= 1000), 64'(1));
        req0 = 1'b0; req1 = 1'b0; res_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
